// File: rtl/accum_warp_looper_memofs_pipe.sv
// AccumWarpLooper memory-offset pipeline: strided/shuffled per-warp offsets -> ND offset -> linear address.
// Optional out-of-bounds flag enabled by defining MEMOFS_OOB_CHECK_EN.
module accum_warp_looper_memofs_pipe #(
  parameter  int N_CFG   = 4,
  parameter  int ABW     = 16,
  parameter  int WBW     = 10,
  parameter  int VDIM    = 2,
  parameter  int DIM     = 2,
  parameter  int SF_BW   = 4,
  parameter  int SS_BW   = 3,
  localparam int NCFG_BW = $clog2(N_CFG + 1),
  localparam int SHW     = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            src_rdy,
  output logic                            src_ack,
  input  logic [NCFG_BW-1:0]              i_id,
  input  logic [VDIM-1:0][WBW-1:0]        i_bofs,
  input  logic [VDIM-1:0][WBW-1:0]        i_aofs,
  input  logic                            i_retire,
  input  logic                            i_islast,
  input  logic [VDIM-1:0][SHW-1:0]        i_global_bshuf,
  input  logic [VDIM-1:0][SHW-1:0]        i_global_ashuf,
  input  logic [VDIM-1:0][SF_BW-1:0]      i_bstride_frac,
  input  logic [VDIM-1:0][SF_BW-1:0]      i_astride_frac,
  input  logic [VDIM-1:0][SS_BW-1:0]      i_bstride_shamt,
  input  logic [VDIM-1:0][SS_BW-1:0]      i_astride_shamt,
  input  logic [ABW-1:0]                  i_linear,
  input  logic [DIM-1:0][ABW-1:0]         i_mboundary,
  output logic                            dst_rdy,
  input  logic                            dst_ack,
  output logic [NCFG_BW-1:0]              o_id,
  output logic                            o_retire,
  output logic                            o_islast,
  output logic [VDIM-1:0][WBW-1:0]        o_bofs,
  output logic [DIM-1:0][WBW-1:0]         o_mofs_nd,
  output logic [ABW-1:0]                  o_linear,
  output logic                            o_oob
);

  localparam int PW = WBW + SF_BW;

  // Stride product is shifted inside the wider product width, then truncated to WBW.
  function automatic logic [WBW-1:0] stride_f(input logic [WBW-1:0]   ofs,
                                              input logic [SF_BW-1:0] frac,
                                              input logic [SS_BW-1:0] shamt);
    logic [PW-1:0] prod;
    prod = PW'(ofs) * PW'(frac);
    prod = prod << shamt;
    return WBW'(prod);
  endfunction

  function automatic logic [ABW-1:0] scale_f(input logic [WBW-1:0] ofs,
                                             input logic [ABW-1:0] extent);
    logic [ABW-1:0] ofs_z;
    ofs_z = ABW'(ofs);
    return ofs_z * extent;
  endfunction

  logic vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic ld_p0, ld_p1, ld_p2;

  logic [VDIM-1:0][WBW-1:0]   bstride_p0_q, bstride_p0_d, astride_p0_q, astride_p0_d;
  logic [VDIM-1:0][SHW-1:0]   bshuf_p0_q, bshuf_p0_d, ashuf_p0_q, ashuf_p0_d;
  logic [ABW-1:0]             linear_p0_q, linear_p0_d;
  logic [DIM-1:0][ABW-1:0]    mb_p0_q, mb_p0_d;
  logic [NCFG_BW-1:0]         id_p0_q, id_p0_d;
  logic                       retire_p0_q, retire_p0_d, islast_p0_q, islast_p0_d;
  logic [VDIM-1:0][WBW-1:0]   bofs_p0_q, bofs_p0_d;

  logic [DIM-1:0][WBW-1:0]    mofs_sum;
  logic [DIM-1:0][WBW-1:0]    mofs_p1_q, mofs_p1_d;
  logic [ABW-1:0]             linear_p1_q, linear_p1_d;
  logic [DIM-1:0][ABW-1:0]    mb_p1_q, mb_p1_d;
  logic [NCFG_BW-1:0]         id_p1_q, id_p1_d;
  logic                       retire_p1_q, retire_p1_d, islast_p1_q, islast_p1_d;
  logic [VDIM-1:0][WBW-1:0]   bofs_p1_q, bofs_p1_d;

  logic [ABW-1:0]             lin_sum;
  logic [DIM-1:0][WBW-1:0]    mofs_p2_q, mofs_p2_d;
  logic [ABW-1:0]             linear_p2_q, linear_p2_d;
  logic [NCFG_BW-1:0]         id_p2_q, id_p2_d;
  logic                       retire_p2_q, retire_p2_d, islast_p2_q, islast_p2_d;
  logic [VDIM-1:0][WBW-1:0]   bofs_p2_q, bofs_p2_d;

  // A stage loads when its upstream holds an item and it is empty or draining this cycle.
  always_comb begin
    ld_p2    = vld_p1_q && (!vld_p2_q || dst_ack);
    ld_p1    = vld_p0_q && (!vld_p1_q || ld_p2);
    ld_p0    = src_rdy  && (!vld_p0_q || ld_p1);
    vld_p2_d = ld_p2 || (vld_p2_q && !dst_ack);
    vld_p1_d = ld_p1 || (vld_p1_q && !ld_p2);
    vld_p0_d = ld_p0 || (vld_p0_q && !ld_p1);
  end

  assign src_ack = ld_p0 && i_rst;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- stage 0: per-offset strides, sample all config ----
  always_comb begin
    bstride_p0_d = bstride_p0_q;
    astride_p0_d = astride_p0_q;
    bshuf_p0_d   = bshuf_p0_q;
    ashuf_p0_d   = ashuf_p0_q;
    linear_p0_d  = linear_p0_q;
    mb_p0_d      = mb_p0_q;
    id_p0_d      = id_p0_q;
    retire_p0_d  = retire_p0_q;
    islast_p0_d  = islast_p0_q;
    bofs_p0_d    = bofs_p0_q;
    if (ld_p0) begin
      for (int v = 0; v < VDIM; v++) begin
        bstride_p0_d[v] = stride_f(i_bofs[v], i_bstride_frac[v], i_bstride_shamt[v]);
        astride_p0_d[v] = stride_f(i_aofs[v], i_astride_frac[v], i_astride_shamt[v]);
      end
      bshuf_p0_d  = i_global_bshuf;
      ashuf_p0_d  = i_global_ashuf;
      linear_p0_d = i_linear;
      mb_p0_d     = i_mboundary;
      id_p0_d     = i_id;
      retire_p0_d = i_retire;
      islast_p0_d = i_islast;
      bofs_p0_d   = i_bofs;
    end
  end

  // ---- stage 1: shuffle strides onto memory dims ----
  always_comb begin
    mofs_sum = '0;
    for (int d = 0; d < DIM; d++) begin
      for (int v = 0; v < VDIM; v++) begin
        if (bshuf_p0_q[v] == SHW'(d)) mofs_sum[d] = mofs_sum[d] + bstride_p0_q[v];
        if (ashuf_p0_q[v] == SHW'(d)) mofs_sum[d] = mofs_sum[d] + astride_p0_q[v];
      end
    end
  end

  always_comb begin
    mofs_p1_d   = mofs_p1_q;
    linear_p1_d = linear_p1_q;
    mb_p1_d     = mb_p1_q;
    id_p1_d     = id_p1_q;
    retire_p1_d = retire_p1_q;
    islast_p1_d = islast_p1_q;
    bofs_p1_d   = bofs_p1_q;
    if (ld_p1) begin
      mofs_p1_d   = mofs_sum;
      linear_p1_d = linear_p0_q;
      mb_p1_d     = mb_p0_q;
      id_p1_d     = id_p0_q;
      retire_p1_d = retire_p0_q;
      islast_p1_d = islast_p0_q;
      bofs_p1_d   = bofs_p0_q;
    end
  end

  always_ff @(posedge i_clk) begin
    bstride_p0_q <= bstride_p0_d;
    astride_p0_q <= astride_p0_d;
    bshuf_p0_q   <= bshuf_p0_d;
    ashuf_p0_q   <= ashuf_p0_d;
    linear_p0_q  <= linear_p0_d;
    mb_p0_q      <= mb_p0_d;
    id_p0_q      <= id_p0_d;
    retire_p0_q  <= retire_p0_d;
    islast_p0_q  <= islast_p0_d;
    bofs_p0_q    <= bofs_p0_d;
    mofs_p1_q    <= mofs_p1_d;
    linear_p1_q  <= linear_p1_d;
    mb_p1_q      <= mb_p1_d;
    id_p1_q      <= id_p1_d;
    retire_p1_q  <= retire_p1_d;
    islast_p1_q  <= islast_p1_d;
    bofs_p1_q    <= bofs_p1_d;
  end

  // ---- stage 2: row-major linearisation; dim d is scaled by the extent of dim d+1 ----
  always_comb begin
    lin_sum = linear_p1_q;
    for (int d = 0; d < DIM - 1; d++) lin_sum = lin_sum + scale_f(mofs_p1_q[d], mb_p1_q[d+1]);
    lin_sum = lin_sum + ABW'(mofs_p1_q[DIM-1]);
  end

  always_comb begin
    mofs_p2_d   = mofs_p2_q;
    linear_p2_d = linear_p2_q;
    id_p2_d     = id_p2_q;
    retire_p2_d = retire_p2_q;
    islast_p2_d = islast_p2_q;
    bofs_p2_d   = bofs_p2_q;
    if (ld_p2) begin
      mofs_p2_d   = mofs_p1_q;
      linear_p2_d = lin_sum;
      id_p2_d     = id_p1_q;
      retire_p2_d = retire_p1_q;
      islast_p2_d = islast_p1_q;
      bofs_p2_d   = bofs_p1_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mofs_p2_q   <= '0;
      linear_p2_q <= '0;
      id_p2_q     <= '0;
      retire_p2_q <= 1'b0;
      islast_p2_q <= 1'b0;
      bofs_p2_q   <= '0;
    end else begin
      mofs_p2_q   <= mofs_p2_d;
      linear_p2_q <= linear_p2_d;
      id_p2_q     <= id_p2_d;
      retire_p2_q <= retire_p2_d;
      islast_p2_q <= islast_p2_d;
      bofs_p2_q   <= bofs_p2_d;
    end
  end

`ifdef MEMOFS_OOB_CHECK_EN
  logic oob_p2_q, oob_p2_d;

  always_comb begin
    oob_p2_d = oob_p2_q;
    if (ld_p2) begin
      oob_p2_d = 1'b0;
      for (int d = 0; d < DIM; d++) begin
        if (ABW'(mofs_p1_q[d]) >= mb_p1_q[d]) oob_p2_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) oob_p2_q <= 1'b0;
    else        oob_p2_q <= oob_p2_d;
  end

  assign o_oob = oob_p2_q;
`else
  // Extent of the outermost dim only matters to the bounds check.
  logic mb0_unused;
  assign mb0_unused = ^mb_p1_q[0];
  assign o_oob      = 1'b0;
`endif

  assign dst_rdy   = vld_p2_q;
  assign o_id      = id_p2_q;
  assign o_retire  = retire_p2_q;
  assign o_islast  = islast_p2_q;
  assign o_bofs    = bofs_p2_q;
  assign o_mofs_nd = mofs_p2_q;
  assign o_linear  = linear_p2_q;

endmodule

// File: tb/tb_accum_warp_looper_memofs_pipe.sv
// Directed bench for accum_warp_looper_memofs_pipe; MEMOFS_OOB_CHECK_EN selects the expected o_oob behaviour.
module tb_accum_warp_looper_memofs_pipe;
  localparam int N_CFG   = 4;
  localparam int ABW     = 16;
  localparam int WBW     = 10;
  localparam int VDIM    = 2;
  localparam int DIM     = 2;
  localparam int SF_BW   = 4;
  localparam int SS_BW   = 3;
  localparam int NCFG_BW = $clog2(N_CFG + 1);
  localparam int SHW     = $clog2(DIM);
`ifdef MEMOFS_OOB_CHECK_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif

  logic                       clk;
  logic                       i_rst;
  logic                       src_rdy, src_ack, dst_rdy, dst_ack;
  logic [NCFG_BW-1:0]         i_id, o_id;
  logic [VDIM-1:0][WBW-1:0]   i_bofs, i_aofs, o_bofs;
  logic                       i_retire, i_islast, o_retire, o_islast;
  logic [VDIM-1:0][SHW-1:0]   i_global_bshuf, i_global_ashuf;
  logic [VDIM-1:0][SF_BW-1:0] i_bstride_frac, i_astride_frac;
  logic [VDIM-1:0][SS_BW-1:0] i_bstride_shamt, i_astride_shamt;
  logic [ABW-1:0]             i_linear, o_linear;
  logic [DIM-1:0][ABW-1:0]    i_mboundary;
  logic [DIM-1:0][WBW-1:0]    o_mofs_nd;
  logic                       o_oob;

  int n_cmp = 0;
  int n_bad = 0;
  int nsent, nrecv;

  accum_warp_looper_memofs_pipe #(
    .N_CFG(N_CFG), .ABW(ABW), .WBW(WBW), .VDIM(VDIM), .DIM(DIM), .SF_BW(SF_BW), .SS_BW(SS_BW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .src_rdy(src_rdy), .src_ack(src_ack),
    .i_id(i_id), .i_bofs(i_bofs), .i_aofs(i_aofs), .i_retire(i_retire), .i_islast(i_islast),
    .i_global_bshuf(i_global_bshuf), .i_global_ashuf(i_global_ashuf),
    .i_bstride_frac(i_bstride_frac), .i_astride_frac(i_astride_frac),
    .i_bstride_shamt(i_bstride_shamt), .i_astride_shamt(i_astride_shamt),
    .i_linear(i_linear), .i_mboundary(i_mboundary),
    .dst_rdy(dst_rdy), .dst_ack(dst_ack),
    .o_id(o_id), .o_retire(o_retire), .o_islast(o_islast), .o_bofs(o_bofs),
    .o_mofs_nd(o_mofs_nd), .o_linear(o_linear), .o_oob(o_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_default();
    i_id            = '0;
    i_bofs          = '0;
    i_aofs          = '0;
    i_retire        = 1'b0;
    i_islast        = 1'b0;
    i_global_bshuf[0] = 1'b0; i_global_bshuf[1] = 1'b1;
    i_global_ashuf[0] = 1'b0; i_global_ashuf[1] = 1'b1;
    i_bstride_frac[0] = 4'd1; i_bstride_frac[1] = 4'd1;
    i_astride_frac[0] = 4'd1; i_astride_frac[1] = 4'd1;
    i_bstride_shamt = '0;
    i_astride_shamt = '0;
    i_linear        = 16'd100;
    i_mboundary[0]  = 16'd8;
    i_mboundary[1]  = 16'd16;
  endtask

  // Issue one item, scramble the config after acceptance, then check 3-cycle latency and results.
  task automatic send_chk(input string tag, input int id, input int m0, input int m1,
                          input int lin, input bit oob, input int b0, input bit ret);
    i_id    = NCFG_BW'(id);
    src_rdy = 1'b1;
    #1;
    chk({tag, ".ack"}, src_ack, 1);
    tick();
    src_rdy        = 1'b0;
    i_linear       = 16'hBEEF;
    i_bofs         = '1;
    i_mboundary    = '0;
    i_global_bshuf = '1;
    i_retire       = 1'b0;
    chk({tag, ".lat1"}, dst_rdy, 0);
    tick();
    chk({tag, ".lat2"}, dst_rdy, 0);
    tick();
    chk({tag, ".lat3"}, dst_rdy, 1);
    chk({tag, ".id"}, o_id, id);
    chk({tag, ".mofs0"}, o_mofs_nd[0], m0);
    chk({tag, ".mofs1"}, o_mofs_nd[1], m1);
    chk({tag, ".linear"}, o_linear, lin);
    chk({tag, ".oob"}, o_oob, oob);
    chk({tag, ".bofs0"}, o_bofs[0], b0);
    chk({tag, ".retire"}, o_retire, ret);
    dst_ack = 1'b1;
    tick();
    dst_ack = 1'b0;
    chk({tag, ".drain"}, dst_rdy, 0);
  endtask

  initial begin
    i_rst   = 1'b0;
    src_rdy = 1'b1;
    dst_ack = 1'b0;
    cfg_default();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.src_ack", src_ack, 0);
    chk("rst.dst_rdy", dst_rdy, 0);
    chk("rst.linear", o_linear, 0);
    chk("rst.id", o_id, 0);
    chk("rst.mofs0", o_mofs_nd[0], 0);
    src_rdy = 1'b0;
    i_rst   = 1'b1;
    tick();
    chk("idle.dst_rdy", dst_rdy, 0);

    // basic identity mapping
    cfg_default();
    i_bofs[0] = 10'd3; i_bofs[1] = 10'd1; i_retire = 1'b1;
    send_chk("t1", 1, 3, 1, 149, 1'b0, 3, 1'b1);

    // strides plus folding of all sources onto dim0; dim1 has no source
    cfg_default();
    i_bofs[0] = 10'd5; i_bofs[1] = 10'd2;
    i_bstride_frac[0] = 4'd3; i_bstride_shamt[0] = 3'd2;
    i_global_bshuf[0] = 1'b0; i_global_bshuf[1] = 1'b0;
    i_aofs[1] = 10'd4;
    i_global_ashuf[0] = 1'b0; i_global_ashuf[1] = 1'b0;
    send_chk("t2", 2, 66, 0, 1156, OOB_EN, 5, 1'b0);

    // stride truncation: 100*15<<7 = 192000, mod 1024 = 512
    cfg_default();
    i_bofs[0] = 10'd100; i_bstride_frac[0] = 4'd15; i_bstride_shamt[0] = 3'd7;
    send_chk("t2b", 3, 512, 0, 8292, OOB_EN, 100, 1'b0);

    // dst_ack on an empty pipe must do nothing
    dst_ack = 1'b1;
    tick();
    tick();
    dst_ack = 1'b0;
    chk("stray_ack.dst_rdy", dst_rdy, 0);

    // address wrap
    cfg_default();
    i_linear = 16'hFFFF; i_bofs[1] = 10'd2;
    send_chk("t4", 4, 0, 2, 1, 1'b0, 0, 1'b0);

    // bounds edges
    cfg_default();
    i_bofs[0] = 10'd8;
    send_chk("t5a", 1, 8, 0, 228, OOB_EN, 8, 1'b0);
    cfg_default();
    i_bofs[0] = 10'd7;
    send_chk("t5b", 2, 7, 0, 212, 1'b0, 7, 1'b0);
    cfg_default();
    i_bofs[1] = 10'd16;
    send_chk("t5c", 3, 0, 16, 116, OOB_EN, 0, 1'b0);

    // backpressure: 5 items offered, sink stalled for 6 cycles
    cfg_default();
    src_rdy = 1'b1;
    dst_ack = 1'b0;
    nsent   = 0;
    for (int c = 0; c < 6; c++) begin
      i_id = NCFG_BW'(nsent + 1);
      i_bofs[0] = WBW'(nsent + 1);
      #1;
      chk($sformatf("bp.ack%0d", c), src_ack, (c < 3) ? 1 : 0);
      if (c >= 3) begin
        chk($sformatf("bp.hold_rdy%0d", c), dst_rdy, 1);
        chk($sformatf("bp.hold_id%0d", c), o_id, 1);
        chk($sformatf("bp.hold_lin%0d", c), o_linear, 116);
      end
      if (src_ack) nsent++;
      tick();
    end
    dst_ack = 1'b1;
    nrecv   = 0;
    for (int c = 0; c < 20 && nrecv < 5; c++) begin
      if (nsent < 5) begin
        src_rdy   = 1'b1;
        i_id      = NCFG_BW'(nsent + 1);
        i_bofs[0] = WBW'(nsent + 1);
      end else begin
        src_rdy = 1'b0;
      end
      #1;
      if (c == 0) chk("bp.both_ack", src_ack, 1);
      if (dst_rdy) begin
        chk($sformatf("bp.id%0d", nrecv + 1), o_id, nrecv + 1);
        chk($sformatf("bp.lin%0d", nrecv + 1), o_linear, 100 + 16 * (nrecv + 1));
        nrecv++;
      end
      if (src_ack) nsent++;
      tick();
    end
    src_rdy = 1'b0;
    dst_ack = 1'b0;
    chk("bp.nsent", nsent, 5);
    chk("bp.nrecv", nrecv, 5);
    tick();
    chk("bp.no_dup", dst_rdy, 0);

    // reset with three items in flight
    cfg_default();
    src_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_id = NCFG_BW'(k + 1);
      tick();
    end
    chk("r6.full", dst_rdy, 1);
    i_rst = 1'b0;
    #1;
    chk("r6.dst_rdy", dst_rdy, 0);
    chk("r6.id", o_id, 0);
    chk("r6.linear", o_linear, 0);
    chk("r6.mofs0", o_mofs_nd[0], 0);
    chk("r6.src_ack", src_ack, 0);
    @(posedge clk);
    #1;
    i_rst   = 1'b1;
    src_rdy = 1'b0;
    tick();
    chk("r6.stale1", dst_rdy, 0);
    tick();
    chk("r6.stale2", dst_rdy, 0);
    cfg_default();
    i_bofs[0] = 10'd6;
    send_chk("t6", 6, 6, 0, 196, 1'b0, 6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
